usb_buffer_arbiter: RTL and testbench
=====================================

// Module: usb_buffer_arbiter
// PURPOSE
//  Parametrised reservation controller for the shared USB packet buffer; it grants the buffer to one
//  transfer at a time (TX fill or RX drain) and tracks progress against buffer occupancy.
//  Adds to the basic IDLE/WRITE/READ reservation FSM: 1-deep request queuing, a stall timeout,
//  size checking and a flush path. Sits between the protocol FSMs and the data buffer.
// PARAMETERS
//  DEPTH        64    buffer capacity in bytes
//  OCC_W        7     occupancy/size width; must be >= $clog2(DEPTH+1)
//  TIMEOUT_CYC  1023  cycles without occupancy change before abort; 0 disables timeout
//  TMO_W        10    timeout counter width; must be >= $clog2(TIMEOUT_CYC+1)
// PORTS
//  clk                 in   1      clock
//  nRst                in   1      reset, asynchronous, active-low
//  txPacketSizeChanged in   1      TX request strobe (1 cycle); size sampled in the same cycle
//  txPacketDataSize    in   OCC_W  bytes expected for the TX packet
//  rxDataReady         in   1      RX drain request strobe (1 cycle)
//  bufferOccupancy     in   OCC_W  current buffer byte count
//  flush               in   1      abort the transfer and clear the buffer (level)
//  bufferReserved      out  1      buffer owned (state != IDLE)
//  owner               out  2      00 none, 01 TX, 10 RX, 11 flush
//  clearBuffer         out  1      buffer clear command, held for the whole FLUSH state
//  txDone              out  1      1-cycle pulse when a TX fill completes
//  rxDone              out  1      1-cycle pulse when an RX drain completes
//  timeoutErr          out  1      1-cycle pulse when a transfer is aborted by timeout
//  sizeErr             out  1      1-cycle pulse on a bad TX size or an overfill
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, pending flags 0, latched size 0, timeout counter 0.
//  All outputs are registered. A strobe sampled at edge N drives the new state and outputs from N+1.
//  States:
//   IDLE  -> FLUSH if flush; else -> WRITE on a TX request; else -> READ on an RX request.
//           TX has priority over RX. A TX request is a strobe or txPend; an RX request is a strobe or rxPend.
//           TX size 0 or > DEPTH: sizeErr pulse, request dropped, stay IDLE.
//           RX request while occupancy == 0: rxDone pulse, stay IDLE.
//   WRITE -> IDLE with txDone when occupancy == latched size.
//           -> FLUSH with sizeErr when occupancy > latched size.
//   READ  -> IDLE with rxDone when occupancy == 0.
//   FLUSH -> clearBuffer = 1; -> IDLE when occupancy == 0 and flush == 0.
//  flush has priority over every other condition in every state.
//  Entering FLUSH clears txPend and rxPend.
//  Queuing: a strobe arriving while state != IDLE, or losing arbitration in IDLE, sets its pend flag.
//   For TX, the size is also stored in a pending-size register; a newer TX strobe overwrites it.
//   The pend flag clears when its request is accepted.
//  Timeout: the counter resets on state entry and on any occupancy change. It increments each
//   WRITE/READ cycle. At TIMEOUT_CYC: timeoutErr pulse, -> FLUSH.
//  Done and error pulses are high in the same cycle that the new state is first visible.
//  Width rules: all compares are unsigned at OCC_W; the counter saturates and never wraps.
//  A completion condition already true on entry (e.g. occupancy == size) exits after 1 WRITE cycle.
// TESTING
//  1 TX size 8, occupancy 0->8 over 8 cycles -> owner 01; txDone 1 cycle at occ=8; IDLE next.
//  2 rxDataReady at occ 5, drain to 0 -> owner 10; rxDone when occ=0. TX strobe size 4
//    mid-drain -> WRITE starts the cycle after rxDone.
//  3 TX and RX strobes in the same cycle -> WRITE first; READ after txDone; nothing lost.
//  4 TX size 0, then size 65 (DEPTH 64) -> sizeErr pulse each time; stays IDLE.
//    WRITE size 4 with occ jumping 3->6 -> sizeErr, FLUSH, clearBuffer until occ=0.
//  5 TIMEOUT_CYC 16, WRITE with occupancy frozen -> timeoutErr at cycle 16, FLUSH, pend flags cleared.
//  6 nRst low mid-WRITE -> outputs 0 asynchronously; IDLE on release; no stale pend.

Source files
------------

// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter: reservation controller granting the shared USB packet buffer to one transfer at a time
//  Ports:
//   clk, nRst                  clock, asynchronous active-low reset
//   txPacketSizeChanged        TX fill request strobe, txPacketDataSize sampled with it
//   rxDataReady                RX drain request strobe
//   bufferOccupancy            current buffer byte count
//   flush                      level request to abort and clear the buffer
//   bufferReserved, owner      ownership status (owner: 00 none, 01 TX, 10 RX, 11 flush)
//   clearBuffer                held high for the whole flush
//   txDone, rxDone             completion pulses
//   timeoutErr, sizeErr        error pulses (stall abort / bad size or overfill)
module usb_buffer_arbiter #(
  parameter int DEPTH       = 64,
  parameter int OCC_W       = 7,
  parameter int TIMEOUT_CYC = 1023,
  parameter int TMO_W       = 10
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             txPacketSizeChanged,
  input  logic [OCC_W-1:0] txPacketDataSize,
  input  logic             rxDataReady,
  input  logic [OCC_W-1:0] bufferOccupancy,
  input  logic             flush,
  output logic             bufferReserved,
  output logic [1:0]       owner,
  output logic             clearBuffer,
  output logic             txDone,
  output logic             rxDone,
  output logic             timeoutErr,
  output logic             sizeErr
);
  typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, READ = 2'b10, FLUSH = 2'b11} state_t;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(TIMEOUT_CYC);
  localparam logic             TMO_EN  = TIMEOUT_CYC != 0;
  state_t           state_q, state_d;
  logic             tx_pend_q, tx_pend_d, rx_pend_q, rx_pend_d;
  logic [OCC_W-1:0] pend_size_q, pend_size_d, size_q, size_d, occ_q, tx_size;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             res_q, clr_q, tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic             tmo_q, tmo_d, size_err_q, size_err_d, tmo_hit, occ_zero;
  logic [1:0]       owner_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit  = TMO_EN && (cnt_inc == TMO_C);
  assign occ_zero = bufferOccupancy == '0;
  // a fresh strobe carries the newest size; otherwise use the queued one
  assign tx_size  = txPacketSizeChanged ? txPacketDataSize : pend_size_q;
  always_comb begin
    state_d     = state_q;
    tx_pend_d   = tx_pend_q | txPacketSizeChanged;
    rx_pend_d   = rx_pend_q | rxDataReady;
    pend_size_d = txPacketSizeChanged ? txPacketDataSize : pend_size_q;
    size_d      = size_q;
    tx_done_d   = 1'b0;
    rx_done_d   = 1'b0;
    tmo_d       = 1'b0;
    size_err_d  = 1'b0;
    if (flush) state_d = FLUSH;
    else
      case (state_q)
        IDLE:
          if (txPacketSizeChanged || tx_pend_q) begin
            tx_pend_d = 1'b0;
            if (tx_size == '0 || tx_size > DEPTH_C) size_err_d = 1'b1;
            else begin
              state_d = WRITE;
              size_d  = tx_size;
            end
          end else if (rxDataReady || rx_pend_q) begin
            rx_pend_d = 1'b0;
            if (occ_zero) rx_done_d = 1'b1;
            else state_d = READ;
          end
        WRITE:
          if (bufferOccupancy == size_q) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else if (bufferOccupancy > size_q) begin
            size_err_d = 1'b1;
            state_d    = FLUSH;
          end else if (tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = FLUSH;
          end
        READ:
          if (occ_zero) begin
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end else if (tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = FLUSH;
          end
        default: if (occ_zero) state_d = IDLE;
      endcase
    if (state_d == FLUSH && state_q != FLUSH) begin
      tx_pend_d = 1'b0;
      rx_pend_d = 1'b0;
    end
    // stall counter only runs while a transfer stays put with occupancy unchanged
    cnt_d = ((state_q == WRITE || state_q == READ) && state_d == state_q && bufferOccupancy == occ_q) ? cnt_inc : '0;
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      tx_pend_q   <= 1'b0;
      rx_pend_q   <= 1'b0;
      pend_size_q <= '0;
      size_q      <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      res_q       <= 1'b0;
      owner_q     <= 2'b00;
      clr_q       <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      tmo_q       <= 1'b0;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_pend_q   <= tx_pend_d;
      rx_pend_q   <= rx_pend_d;
      pend_size_q <= pend_size_d;
      size_q      <= size_d;
      occ_q       <= bufferOccupancy;
      cnt_q       <= cnt_d;
      res_q       <= state_d != IDLE;
      owner_q     <= state_d;
      clr_q       <= state_d == FLUSH;
      tx_done_q   <= tx_done_d;
      rx_done_q   <= rx_done_d;
      tmo_q       <= tmo_d;
      size_err_q  <= size_err_d;
    end
  end
  assign bufferReserved = res_q;
  assign owner          = owner_q;
  assign clearBuffer    = clr_q;
  assign txDone         = tx_done_q;
  assign rxDone         = rx_done_q;
  assign timeoutErr     = tmo_q;
  assign sizeErr        = size_err_q;
endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// tb_usb_buffer_arbiter: directed vectors for usb_buffer_arbiter with hand-computed output words
module tb_usb_buffer_arbiter;
  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       tx_stb = 1'b0, rx_stb = 1'b0, flush = 1'b0;
  logic [6:0] tx_size = '0, occ = '0;
  logic       res, clr, txd, rxd, tmo, serr;
  logic [1:0] owner;
  logic [7:0] o;
  int         vectors = 0, miscompares = 0;
  // output word {reserved, owner, clear, txDone, rxDone, timeoutErr, sizeErr}
  localparam logic [7:0] IDL = 8'h00, WR = 8'hA0, RD = 8'hC0, FL = 8'hF0;
  localparam logic [7:0] TXD = 8'h08, RXD = 8'h04, FL_TMO = 8'hF2, FL_SERR = 8'hF1, SERR = 8'h01;
  usb_buffer_arbiter #(.DEPTH(64), .OCC_W(7), .TIMEOUT_CYC(16), .TMO_W(5)) dut (
    .clk(clk), .nRst(nRst), .txPacketSizeChanged(tx_stb), .txPacketDataSize(tx_size),
    .rxDataReady(rx_stb), .bufferOccupancy(occ), .flush(flush),
    .bufferReserved(res), .owner(owner), .clearBuffer(clr), .txDone(txd), .rxDone(rxd),
    .timeoutErr(tmo), .sizeErr(serr)
  );
  assign o = {res, owner, clr, txd, rxd, tmo, serr};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tx(input logic [6:0] s);
    tx_stb = 1'b1;
    tx_size = s;
    tick();
    tx_stb = 1'b0;
  endtask
  initial begin
    #12 nRst = 1'b1;
    tick();
    check("reset", o, IDL);
    // 1: TX fill of 8 bytes
    tx(7'd8);
    check("t1 grant", o, WR);
    for (int i = 1; i <= 8; i++) begin
      occ = 7'(i);
      tick();
      check("t1 fill", o, i == 8 ? TXD : WR);
    end
    tick();
    check("t1 idle", o, IDL);
    // 2: RX drain with a TX request queued mid-drain
    occ = 7'd5;
    rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
    check("t2 grant", o, RD);
    occ = 7'd4;
    tick();
    check("t2 drain4", o, RD);
    occ = 7'd3;
    tx(7'd4);
    check("t2 queued", o, RD);
    occ = 7'd2;
    tick();
    occ = 7'd1;
    tick();
    check("t2 drain1", o, RD);
    occ = 7'd0;
    tick();
    check("t2 rxdone", o, RXD);
    tick();
    check("t2 pend write", o, WR);
    for (int i = 1; i <= 4; i++) begin
      occ = 7'(i);
      tick();
    end
    check("t2 txdone", o, TXD);
    // 3: simultaneous TX and RX, TX first
    occ = 7'd0;
    tick();
    rx_stb = 1'b1;
    tx(7'd2);
    rx_stb = 1'b0;
    check("t3 tx first", o, WR);
    occ = 7'd1;
    tick();
    occ = 7'd2;
    tick();
    check("t3 txdone", o, TXD);
    tick();
    check("t3 rx next", o, RD);
    occ = 7'd1;
    tick();
    occ = 7'd0;
    tick();
    check("t3 rxdone", o, RXD);
    tick();
    check("t3 idle", o, IDL);
    // 4: size errors and overfill
    tx(7'd0);
    check("t4 size0", o, SERR);
    tick();
    check("t4 size0 idle", o, IDL);
    tx(7'd65);
    check("t4 size65", o, SERR);
    tick();
    check("t4 size65 idle", o, IDL);
    tx(7'd64);
    check("t4 size64 ok", o, WR);
    occ = 7'd64;
    tick();
    check("t4 size64 done", o, TXD);
    occ = 7'd0;
    tick();
    tx(7'd4);
    check("t4 write", o, WR);
    occ = 7'd3;
    tick();
    check("t4 occ3", o, WR);
    occ = 7'd6;
    tick();
    check("t4 overfill", o, FL_SERR);
    tick();
    check("t4 clear held", o, FL);
    occ = 7'd0;
    tick();
    check("t4 flush done", o, IDL);
    // 5: stall timeout, pends cleared on entering flush
    tx(7'd4);
    check("t5 write", o, WR);
    rx_stb = 1'b1;
    tx(7'd4);
    rx_stb = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("t5 before tmo", o, WR);
    tick();
    check("t5 timeout", o, FL_TMO);
    tick();
    check("t5 flush exit", o, IDL);
    tick();
    check("t5 no pend", o, IDL);
    // flush level has priority and holds FLUSH
    tx(7'd4);
    flush = 1'b1;
    tick();
    check("t5 flush in write", o, FL);
    tick();
    check("t5 flush held", o, FL);
    flush = 1'b0;
    tick();
    check("t5 flush release", o, IDL);
    // 6: asynchronous reset mid-WRITE with a pending RX
    tx(7'd8);
    occ = 7'd3;
    rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
    check("t6 write", o, WR);
    #2 nRst = 1'b0;
    #1 check("t6 async reset", o, IDL);
    occ = 7'd0;
    tick();
    #2 nRst = 1'b1;
    tick();
    check("t6 idle", o, IDL);
    tick();
    check("t6 no stale pend", o, IDL);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
